// File: rtl/simd_operand_gather.sv
// Gathers a serial element stream into one packed {B,A} operand word for the SIMD adder,
// holding it on dout/dvld until the adder's rdy accepts it; flush emits a zero-padded partial word.
module simd_operand_gather #(
    parameter int unsigned SIMD_WIDTH = 1,
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned MIWIDTH    = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [ELEM_WIDTH-1:0]                 in_data,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic                                  flush,
    output logic [MIWIDTH-1:0]                    dout,
    output logic                                  dvld,
    input  logic                                  rdy,
    output logic                                  vec_partial,
    output logic [$clog2(2*SIMD_WIDTH+1)-1:0]     vec_count
);

    localparam int unsigned NUM_ELEMS = 2 * SIMD_WIDTH;
    localparam int unsigned CW        = $clog2(NUM_ELEMS + 1);

    // The packed word must hold exactly both operands.
    generate
        if (MIWIDTH != NUM_ELEMS * ELEM_WIDTH) begin : g_bad_cfg
            $error("simd_operand_gather: MIWIDTH must equal 2*SIMD_WIDTH*ELEM_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MIWIDTH-1:0]   dout_q, dout_d;
    logic                 dvld_q, dvld_d;
    logic                 partial_q, partial_d;

    logic                 accept;
    logic [CW-1:0]        cnt_inc;
    logic [CW-1:0]        cnt_after;

    // Acceptance handshake is combinational so the feeder sees ready in the same cycle.
    assign in_rdy = en & (state_q == FILL) & ~rst;
    assign accept = in_vld & in_rdy;

    // State, gathered lanes and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            dout_q    <= '0;
            dvld_q    <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            dvld_q    <= dvld_d;
            partial_q <= partial_d;
        end
    end

    // Next-state: store the arriving element first, then decide on full issue or flush.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        dvld_d    = dvld_q;
        partial_d = partial_q;
        cnt_inc   = cnt_q + CW'(1);
        cnt_after = cnt_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < int'(NUM_ELEMS); i++) begin
                        if (CW'(i) == cnt_q) begin
                            dout_d[i*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
                        end
                    end
                    cnt_after = cnt_inc;
                end
                cnt_d = cnt_after;

                if (accept && (cnt_q == CW'(NUM_ELEMS - 1))) begin
                    state_d   = ISSUE;
                    dvld_d    = 1'b1;
                    partial_d = 1'b0;
                end else if (flush && (cnt_after != '0)) begin
                    // Lanes not yet filled in this vector still hold stale data.
                    for (int i = 0; i < int'(NUM_ELEMS); i++) begin
                        if (CW'(i) >= cnt_after) begin
                            dout_d[i*ELEM_WIDTH +: ELEM_WIDTH] = '0;
                        end
                    end
                    state_d   = ISSUE;
                    dvld_d    = 1'b1;
                    partial_d = 1'b1;
                end
            end
            ISSUE: begin
                if (rdy) begin
                    state_d   = FILL;
                    dvld_d    = 1'b0;
                    partial_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign dout        = dout_q;
    assign dvld        = dvld_q;
    assign vec_partial = partial_q;
    assign vec_count   = cnt_q;

endmodule

// File: tb/tb_simd_operand_gather.sv
// Directed bench for simd_operand_gather at SIMD_WIDTH=2, ELEM_WIDTH=8, plus a gap-stressed
// stream checked against a small gather model.
module tb_simd_operand_gather;

    localparam int unsigned SW = 2;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 32;
    localparam int unsigned NE = 2 * SW;
    localparam int unsigned CW = $clog2(NE + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [EW-1:0] in_data;
    logic          in_vld;
    logic          in_rdy;
    logic          flush;
    logic [MW-1:0] dout;
    logic          dvld;
    logic          rdy;
    logic          vec_partial;
    logic [CW-1:0] vec_count;

    int n_total = 0;
    int n_pass  = 0;

    simd_operand_gather #(
        .SIMD_WIDTH (SW),
        .ELEM_WIDTH (EW),
        .MIWIDTH    (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .flush       (flush),
        .dout        (dout),
        .dvld        (dvld),
        .rdy         (rdy),
        .vec_partial (vec_partial),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [EW-1:0] d);
        in_data = d;
        in_vld  = 1'b1;
        tick();
        in_vld  = 1'b0;
    endtask

    // Gap-stressed stream state
    logic [MW-1:0] m_word;
    int            m_cnt;
    logic          m_issue;
    logic          m_rdy;
    int            vecs_done;
    int            cycles;

    initial begin
        rst = 1'b1; en = 1'b1; in_data = '0; in_vld = 1'b0; flush = 1'b0; rdy = 1'b0;
        tick(); tick();
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_dvld", 64'(dvld), 64'd0);
        check("rst_cnt", 64'(vec_count), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_partial", 64'(vec_partial), 64'd0);
        check("idle_in_rdy", 64'(in_rdy), 64'd1);

        // Full vector, rdy held high
        rdy = 1'b1;
        in_vld = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        check("cnt3", 64'(vec_count), 64'd3);
        check("dvld_before_last", 64'(dvld), 64'd0);
        in_data = 8'h44; tick();
        in_vld = 1'b0;
        #1;
        check("full_dvld", 64'(dvld), 64'd1);
        check("full_dout", 64'(dout), 64'h44332211);
        check("full_partial", 64'(vec_partial), 64'd0);
        check("issue_in_rdy", 64'(in_rdy), 64'd0);
        tick();
        check("full_dvld_1cyc", 64'(dvld), 64'd0);
        check("full_cnt_clr", 64'(vec_count), 64'd0);
        check("bubble_in_rdy", 64'(in_rdy), 64'd1);

        // Back-pressure: hold for 5 cycles, extra input ignored
        rdy = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        in_vld = 1'b1; in_data = 8'h99;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("hold_dvld", 64'(dvld), 64'd1);
            check("hold_dout", 64'(dout), 64'h44332211);
            check("hold_in_rdy", 64'(in_rdy), 64'd0);
            tick();
        end
        in_vld = 1'b0;
        rdy = 1'b1;
        tick();
        check("hold_release_dvld", 64'(dvld), 64'd0);
        check("hold_release_cnt", 64'(vec_count), 64'd0);
        check("hold_release_dout", 64'(dout), 64'h44332211);

        // Flush of a partial vector
        send(8'hAA); send(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_dvld", 64'(dvld), 64'd1);
        check("flush_dout", 64'(dout), 64'h0000BBAA);
        check("flush_partial", 64'(vec_partial), 64'd1);
        check("flush_cnt", 64'(vec_count), 64'd2);
        tick();
        check("flush_done_dvld", 64'(dvld), 64'd0);
        check("flush_done_partial", 64'(vec_partial), 64'd0);

        // Flush while empty does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty_flush_dvld", 64'(dvld), 64'd0);
        check("empty_flush_cnt", 64'(vec_count), 64'd0);
        tick();
        check("empty_flush_dvld2", 64'(dvld), 64'd0);

        // Flush coinciding with the last element
        send(8'h01); send(8'h02); send(8'h03);
        in_data = 8'h04; in_vld = 1'b1; flush = 1'b1;
        tick();
        in_vld = 1'b0; flush = 1'b0;
        check("flushlast_dvld", 64'(dvld), 64'd1);
        check("flushlast_dout", 64'(dout), 64'h04030201);
        check("flushlast_partial", 64'(vec_partial), 64'd0);
        tick();
        check("flushlast_done", 64'(dvld), 64'd0);
        tick();
        check("flushlast_single", 64'(dvld), 64'd0);

        // en pause mid-fill
        send(8'h11); send(8'h22);
        en = 1'b0; in_vld = 1'b1; in_data = 8'hEE;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("pause_in_rdy", 64'(in_rdy), 64'd0);
            check("pause_cnt", 64'(vec_count), 64'd2);
            tick();
        end
        in_vld = 1'b0; en = 1'b1;
        send(8'h33); send(8'h44);
        check("resume_dvld", 64'(dvld), 64'd1);
        check("resume_dout", 64'(dout), 64'h44332211);
        tick();

        // en low during issue does not block handoff
        rdy = 1'b0;
        send(8'h5A); send(8'h6B); send(8'h7C); send(8'h8D);
        en = 1'b0; rdy = 1'b1;
        tick();
        check("en_low_handoff", 64'(dvld), 64'd0);
        en = 1'b1;

        // Reset during issue and during fill
        rdy = 1'b0;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        check("pre_rst_dvld", 64'(dvld), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_high_in_rdy", 64'(in_rdy), 64'd0);
        tick();
        check("rst_issue_dvld", 64'(dvld), 64'd0);
        check("rst_issue_cnt", 64'(vec_count), 64'd0);
        check("rst_issue_dout", 64'(dout), 64'd0);
        check("rst_issue_partial", 64'(vec_partial), 64'd0);
        rst = 1'b0;
        send(8'hD1); send(8'hD2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_fill_cnt", 64'(vec_count), 64'd0);
        send(8'hE1);
        check("post_rst_cnt", 64'(vec_count), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // Gap-stressed stream against a gather model
        m_word = '0; m_cnt = 0; m_issue = 1'b0; vecs_done = 0; cycles = 0;
        while (vecs_done < 40 && cycles < 4000) begin
            en      = ($urandom_range(0, 7) != 0);
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = EW'($urandom);
            m_rdy   = ($urandom_range(0, 1) != 0);
            rdy     = m_rdy;
            #1;
            check("rnd_in_rdy", 64'(in_rdy), 64'(en & ~m_issue));
            check("rnd_dvld", 64'(dvld), 64'(m_issue));
            if (m_issue) begin
                check("rnd_dout", 64'(dout), 64'(m_word));
                if (m_rdy) begin
                    m_issue = 1'b0;
                    m_cnt   = 0;
                    vecs_done++;
                end
            end else if (en && in_vld) begin
                m_word[m_cnt*EW +: EW] = in_data;
                m_cnt++;
                if (m_cnt == int'(NE)) m_issue = 1'b1;
            end
            tick();
            cycles++;
        end
        check("rnd_vectors_done", 64'(vecs_done), 64'd40);
        in_vld = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
